varredura_display: RTL and testbench
====================================

// Module: varredura_display
// PURPOSE
//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//  Consumes one slow tap of the 18-bit ripple frequency divider (~190 Hz bit) as scan_tick_in.
//  Synchronises that tap into the 50 MHz domain and advances one digit per tick rising edge.
//  Drives the anode select, the hex-decoded segment pattern and the decimal point.
// PARAMETERS
//  N_DIGITS  4  number of multiplexed digits (2..8)
// PORTS
//  clock_in      in   1           50 MHz system clock; every register is clocked on its rising edge
//  reset         in   1           synchronous, active-high reset
//  scan_tick_in  in   1           divider tap; ripple-derived, so treated as asynchronous
//  enable_in     in   1           1 = scan active; 0 = display dark
//  digits_in     in   4*N_DIGITS  hex nibble per digit; digit k = digits_in[4k+3:4k]
//  dp_in         in   N_DIGITS    decimal point per digit, 1 = lit
//  blank_in      in   N_DIGITS    1 = digit k dark (anode still scanned, segs off)
//  anode_out     out  N_DIGITS    one-cold anode select, active low
//  seg_out       out  7           {g,f,e,d,c,b,a}, active low
//  dp_out        out  1           decimal point, active low
//  digit_idx     out  ceil(log2 N) index of the digit currently selected
// BEHAVIOUR
//  Reset, synchronous and dominant over every other input:
//   - anode_out = all 1s; seg_out = 7'h7F; dp_out = 1; digit_idx = 0; state = BLANK
//   - synchroniser flops and the edge-detect flop cleared to 0
//  Tick path:
//   - 2-flop synchroniser, then a previous-value flop
//   - step = sync & ~prev, exactly one clock_in pulse per tick rising edge
//   - step asserts on the 3rd clock_in edge after scan_tick_in rises; a held-high tick steps once only
//  FSM states (all outputs registered):
//   IDLE: all anodes off, seg 7F, dp 1; digit_idx held
//     - enable_in=1 -> BLANK
//     - steps are ignored in IDLE and are not queued
//   BLANK: anti-ghosting gap, exactly 1 cycle, all anodes off
//     - -> SHOW unconditionally; enable_in=0 -> IDLE
//   SHOW: anode_out[digit_idx]=0, all other anodes 1
//     - seg_out = decode(digit), dp_out = ~dp_in[digit_idx]
//     - digits_in, dp_in and blank_in are live: a change appears on the outputs 1 cycle later
//     - blank_in[digit_idx]=1 -> seg 7F, dp 1, anode still driven
//     - step -> digit_idx = (idx==N_DIGITS-1) ? 0 : idx+1, then BLANK
//     - enable_in=0 -> IDLE; this wins over a simultaneous step and idx is not advanced
//  Timing, step to display: the new anode goes low 2 cycles after step (1 BLANK cycle + register)
//  Decode, active low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
//  Reset mid-scan: returns to idx 0 / BLANK on the next edge regardless of state
// TESTING
//  1. Hold reset 3 cycles -> anode_out=4'hF, seg_out=7F, dp_out=1, digit_idx=0.
//  2. digits_in=16'h1234, enable=1, pulse tick 4 times ->
//     - anode sequence 1110/1101/1011/0111
//     - seg 19/30/24/79
//     - each new anode exactly 5 clocks after the tick rises, preceded by 1 all-off cycle
//  3. Fifth tick -> digit_idx wraps 3->0, anode 1110; tick held high 1000 cycles -> no further step.
//  4. blank_in=4'b0010, dp_in=4'b0001 -> digit 1 shows seg 7F with anode 1101; digit 0 shows dp_out=0.
//  5. enable_in=0 on the same cycle as a step while in SHOW idx=2 ->
//     - all anodes off next cycle
//     - re-enable -> resumes at idx 2 after 1 BLANK cycle
//  6. Assert reset while in SHOW idx=3 -> next cycle all outputs at reset values, digit_idx=0.

Source files
------------

// File: rtl/varredura_display.sv
// Scan controller for a time-multiplexed common-anode 7-segment display.
// A ripple-divider tap is synchronised and edge-detected; each rising edge advances one digit.
module varredura_display #(
  parameter  int N_DIGITS = 4,
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  scan_tick_in,
  input  logic                  enable_in,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  output logic [N_DIGITS-1:0]   anode_out,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [IDX_W-1:0]      digit_idx
);

  // BLANK is a one-cycle anti-ghosting gap between consecutive digits.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic sync1_q, sync2_q, prev_q, step_q;

  logic [3:0] sel_nib;
  logic       sel_dp;
  logic       sel_blank;
  logic       idx_last;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // step_q is registered so the FSM sees one clean pulse per tick rising edge.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      sync1_q <= scan_tick_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      step_q  <= sync2_q & ~prev_q;
    end
  end

  assign idx_last = (idx_q == IDX_W'(N_DIGITS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    anode_d   = '1;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_in) state_d = ST_BLANK;
      end
      ST_BLANK: begin
        state_d = enable_in ? ST_SHOW : ST_IDLE;
      end
      ST_SHOW: begin
        if (!enable_in) begin
          state_d = ST_IDLE;
        end else if (step_q) begin
          idx_d   = idx_last ? '0 : idx_q + 1'b1;
          state_d = ST_BLANK;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    // Outputs are registered against the next state so they settle with it.
    if (state_d == ST_SHOW) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (idx_d == IDX_W'(k)) begin
          anode_d[k] = 1'b0;
          sel_nib    = digits_in[4*k +: 4];
          sel_dp     = dp_in[k];
          sel_blank  = blank_in[k];
        end
      end
      if (!sel_blank) begin
        seg_d = decode(sel_nib);
        dp_d  = ~sel_dp;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= ST_BLANK;
      idx_q   <= '0;
      anode_q <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign anode_out = anode_q;
  assign seg_out   = seg_q;
  assign dp_out    = dp_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_varredura_display.sv
// Self-checking bench for varredura_display: scan order, tick latency, blanking,
// decimal point, enable abort and mid-scan reset, checked through an expected-value queue.
module tb_varredura_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_tick;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_o;
  logic [1:0]  idx;

  always #5 clk = ~clk;

  varredura_display #(.N_DIGITS(4)) dut (
    .clock_in     (clk),
    .reset        (reset),
    .scan_tick_in (scan_tick),
    .enable_in    (enable),
    .digits_in    (digits),
    .dp_in        (dp),
    .blank_in     (blank),
    .anode_out    (anode),
    .seg_out      (seg),
    .dp_out       (dp_o),
    .digit_idx    (idx)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
  } obs_t;

  obs_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic obs_t model_show(input int k);
    obs_t e;
    e.an    = 4'hF;
    e.an[k] = 1'b0;
    if (blank[k]) begin
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end else begin
      e.seg = dec_tbl[digits[4*k +: 4]];
      e.dp  = ~dp[k];
    end
    e.idx = 2'(k);
    return e;
  endfunction

  function automatic obs_t model_dark(input int k);
    obs_t e;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.idx = 2'(k);
    return e;
  endfunction

  function automatic obs_t obs();
    return {anode, seg, dp_o, idx};
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for an all-off gap followed by a driven anode.
  task automatic wait_new_anode(output int cyc, output int nblank);
    bit done;
    done   = 1'b0;
    cyc    = 0;
    nblank = 0;
    while (!done && cyc < 40) begin
      clk1();
      cyc++;
      if (anode == 4'hF) nblank++;
      else if (nblank > 0) done = 1'b1;
    end
  endtask

  task automatic run_tick(output int cyc, output int nblank, output obs_t got);
    scan_tick = 1'b1;
    wait_new_anode(cyc, nblank);
    got = obs();
    scan_tick = 1'b0;
    repeat (4) clk1();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; scan_tick = 1'b0;
    digits = 16'h0000; dp = 4'h0; blank = 4'h0;
    repeat (3) clk1();
    n_total++; if (anode !== 4'hF) $display("FAIL reset_anode got=%h exp=f", anode); else n_pass++;
    n_total++; if (seg !== 7'h7F) $display("FAIL reset_seg got=%h exp=7f", seg); else n_pass++;
    n_total++; if (dp_o !== 1'b1) $display("FAIL reset_dp got=%b exp=1", dp_o); else n_pass++;
    n_total++; if (idx !== 2'd0) $display("FAIL reset_idx got=%0d exp=0", idx); else n_pass++;
    reset = 1'b0;
    repeat (2) clk1();
  endtask

  task automatic test_scan();
    int cyc, nb;
    obs_t got, exp;
    digits = 16'h1234;
    enable = 1'b1;
    sb_q.push_back(model_show(0));
    wait_new_anode(cyc, nb);
    got = obs();
    exp = sb_q.pop_front();
    n_total++; if (got !== exp) $display("FAIL scan_enable got=%h exp=%h", got, exp); else n_pass++;
    n_total++; if (cyc !== 2) $display("FAIL scan_enable_lat got=%0d exp=2", cyc); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      sb_q.push_back(model_show(k));
      run_tick(cyc, nb, got);
      exp = sb_q.pop_front();
      n_total++; if (got !== exp) $display("FAIL scan_d%0d got=%h exp=%h", k, got, exp); else n_pass++;
      n_total++; if (cyc !== 5) $display("FAIL scan_lat_d%0d got=%0d exp=5", k, cyc); else n_pass++;
      n_total++; if (nb !== 1) $display("FAIL scan_gap_d%0d got=%0d exp=1", k, nb); else n_pass++;
    end
  endtask

  task automatic test_wrap_hold();
    int cyc, nb, changes;
    obs_t got, exp;
    sb_q.push_back(model_show(0));
    scan_tick = 1'b1;
    wait_new_anode(cyc, nb);
    got = obs();
    exp = sb_q.pop_front();
    n_total++; if (got !== exp) $display("FAIL wrap got=%h exp=%h", got, exp); else n_pass++;
    n_total++; if (cyc !== 5) $display("FAIL wrap_lat got=%0d exp=5", cyc); else n_pass++;
    changes = 0;
    repeat (1000) begin
      clk1();
      if (anode !== 4'hE || idx !== 2'd0) changes++;
    end
    n_total++; if (changes !== 0) $display("FAIL hold_step got=%0d exp=0", changes); else n_pass++;
    scan_tick = 1'b0;
    repeat (4) clk1();
    digits = 16'h123A;
    clk1();
    sb_q.push_back(model_show(0));
    got = obs();
    exp = sb_q.pop_front();
    n_total++; if (got !== exp) $display("FAIL live_digit got=%h exp=%h", got, exp); else n_pass++;
  endtask

  task automatic test_blank_dp();
    int cyc, nb;
    obs_t got, exp;
    digits = 16'h1234;
    blank  = 4'b0010;
    dp     = 4'b0001;
    clk1();
    sb_q.push_back(model_show(0));
    got = obs();
    exp = sb_q.pop_front();
    n_total++; if (got !== exp) $display("FAIL dp_d0 got=%h exp=%h", got, exp); else n_pass++;
    for (int k = 1; k < 3; k++) begin
      sb_q.push_back(model_show(k));
      run_tick(cyc, nb, got);
      exp = sb_q.pop_front();
      n_total++; if (got !== exp) $display("FAIL blank_d%0d got=%h exp=%h", k, got, exp); else n_pass++;
    end
  endtask

  task automatic test_enable_abort();
    int cyc, nb;
    obs_t got, exp;
    scan_tick = 1'b1;
    repeat (3) clk1();
    enable = 1'b0;
    sb_q.push_back(model_dark(2));
    clk1();
    got = obs();
    exp = sb_q.pop_front();
    n_total++; if (got !== exp) $display("FAIL abort got=%h exp=%h", got, exp); else n_pass++;
    scan_tick = 1'b0;
    repeat (4) clk1();
    scan_tick = 1'b1;
    repeat (6) clk1();
    scan_tick = 1'b0;
    repeat (4) clk1();
    sb_q.push_back(model_dark(2));
    got = obs();
    exp = sb_q.pop_front();
    n_total++; if (got !== exp) $display("FAIL idle_tick got=%h exp=%h", got, exp); else n_pass++;
    enable = 1'b1;
    sb_q.push_back(model_show(2));
    wait_new_anode(cyc, nb);
    got = obs();
    exp = sb_q.pop_front();
    n_total++; if (got !== exp) $display("FAIL resume got=%h exp=%h", got, exp); else n_pass++;
    n_total++; if (cyc !== 2) $display("FAIL resume_lat got=%0d exp=2", cyc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc, nb;
    obs_t got, exp;
    sb_q.push_back(model_show(3));
    run_tick(cyc, nb, got);
    exp = sb_q.pop_front();
    n_total++; if (got !== exp) $display("FAIL pre_reset got=%h exp=%h", got, exp); else n_pass++;
    reset = 1'b1;
    clk1();
    sb_q.push_back(model_dark(0));
    got = obs();
    exp = sb_q.pop_front();
    n_total++; if (got !== exp) $display("FAIL mid_reset got=%h exp=%h", got, exp); else n_pass++;
    reset = 1'b0;
    clk1();
    sb_q.push_back(model_show(0));
    got = obs();
    exp = sb_q.pop_front();
    n_total++; if (got !== exp) $display("FAIL post_reset got=%h exp=%h", got, exp); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; scan_tick = 1'b0;
    digits = 16'h0000; dp = 4'h0; blank = 4'h0;
    clk1();
    test_reset();
    test_scan();
    test_wrap_hold();
    test_blank_dp();
    test_enable_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
